// File: rtl/s1_issue_controller_if.sv
// Fetch-side handshake and S1 issue bus of the issue controller.
// The controller takes the slave side; the fetch/S1 environment takes the master side.
interface s1_issue_controller_if;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        flush;
  logic [31:0] issue_instr;
  logic        issue_valid;
  logic        stall;
  logic [15:0] stall_count;

  modport slave (
    input  instr_valid, instr, flush,
    output instr_ready, issue_instr, issue_valid, stall, stall_count
  );

  modport master (
    output instr_valid, instr, flush,
    input  instr_ready, issue_instr, issue_valid, stall, stall_count
  );
endinterface

// File: rtl/s1_issue_controller.sv
// Holds one fetched word and issues it to S1 when free of RAW hazards, else a zero bubble; one edge from accept to issue.
// instr_ready drops while the pending word is hazard-blocked, during flush, and while reset is held.
module s1_issue_controller #(
  parameter int HAZ_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  s1_issue_controller_if.slave bus
);
  logic [31:0]               pend_word;
  logic                      pend_valid;
  logic [HAZ_DEPTH-1:0]      sb_we;
  logic [HAZ_DEPTH-1:0][4:0] sb_dest;
  logic [31:0]               issue_instr_q;
  logic                      issue_valid_q;
  logic [15:0]               stall_cnt;

  logic [4:0] ws, rs1, rs2;
  logic       imm_form;
  logic       pend_writes;
  logic       hazard;
  logic       issue_now;
  logic       accept;

  assign ws          = pend_word[25:21];
  assign rs1         = pend_word[20:16];
  assign rs2         = pend_word[15:11];
  assign imm_form    = pend_word[29];
  assign pend_writes = (pend_word != 32'h0) && (ws != 5'd0);

  // Scoreboard entries never carry r0 with we set, so r0 sources cannot match.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      if (sb_we[i] && ((sb_dest[i] == rs1) || (!imm_form && (sb_dest[i] == rs2))))
        hazard = 1'b1;
    end
    hazard = hazard && pend_valid;
  end

  assign issue_now = pend_valid && !hazard;
  assign accept    = bus.instr_valid && bus.instr_ready;

  assign bus.instr_ready = rst && !bus.flush && !hazard;
  assign bus.stall       = hazard;
  assign bus.issue_instr = issue_instr_q;
  assign bus.issue_valid = issue_valid_q;
  assign bus.stall_count = stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_word     <= '0;
      pend_valid    <= 1'b0;
      sb_we         <= '0;
      sb_dest       <= '0;
      issue_instr_q <= '0;
      issue_valid_q <= 1'b0;
      stall_cnt     <= '0;
    end else if (bus.flush) begin
      pend_valid    <= 1'b0;
      sb_we         <= '0;
      issue_instr_q <= '0;
      issue_valid_q <= 1'b0;
    end else begin
      for (int i = HAZ_DEPTH - 1; i > 0; i--) begin
        sb_we[i]   <= sb_we[i-1];
        sb_dest[i] <= sb_dest[i-1];
      end
      sb_we[0]      <= issue_now && pend_writes;
      sb_dest[0]    <= ws;
      issue_instr_q <= issue_now ? pend_word : 32'h0;
      issue_valid_q <= issue_now;
      if (hazard && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      // A word accepted on the issuing edge replaces the one leaving.
      if (accept) begin
        pend_word  <= bus.instr;
        pend_valid <= 1'b1;
      end else if (issue_now) begin
        pend_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_s1_issue_controller.sv
// Randomized and directed bench for s1_issue_controller against a timestamp-based hazard model.
module tb_s1_issue_controller;
  localparam int HAZ = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  s1_issue_controller_if bif();

  s1_issue_controller #(.HAZ_DEPTH(HAZ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a register is busy if a write to it issued within the last HAZ edges.
  int          edge_no;
  int          last_wr [32];
  bit          m_pv;
  logic [31:0] m_pend;
  logic [31:0] m_issue;
  bit          m_ivld;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit busy(input logic [4:0] r);
    return (r != 5'd0) && ((edge_no - last_wr[r]) <= HAZ);
  endfunction

  function automatic bit m_haz();
    logic [4:0] a, b;
    a = m_pend[20:16];
    b = m_pend[15:11];
    return m_pv && (busy(a) || (!m_pend[29] && busy(b)));
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) last_wr[r] = -1000;
    m_pv = 0; m_pend = '0; m_issue = '0; m_ivld = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit v, input logic [31:0] w, input bit f);
    bit haz, acc;
    logic [4:0] d;
    haz = m_haz();
    acc = v && !f && !haz;
    if (f) begin
      m_pv = 0; m_issue = '0; m_ivld = 0;
      for (int r = 0; r < 32; r++) last_wr[r] = -1000;
    end else begin
      if (m_pv && !haz) begin
        m_issue = m_pend; m_ivld = 1;
        d = m_pend[25:21];
        if (m_pend != 0 && d != 0) last_wr[d] = edge_no;
        m_pv = 0;
      end else begin
        m_issue = '0; m_ivld = 0;
        if (haz && m_cnt < 16'hFFFF) m_cnt++;
      end
      if (acc) begin m_pv = 1; m_pend = w; end
    end
    edge_no++;
  endtask

  // One cycle: drive, check combinational outputs, clock, check registered outputs.
  task automatic step(input bit v, input logic [31:0] w, input bit f);
    bif.instr_valid = v; bif.instr = w; bif.flush = f;
    #1;
    check("instr_ready", {31'b0, bif.instr_ready}, {31'b0, !f && !m_haz()});
    check("stall", {31'b0, bif.stall}, {31'b0, m_haz()});
    @(posedge clk);
    model_edge(v, w, f);
    #1;
    check("issue_instr", bif.issue_instr, m_issue);
    check("issue_valid", {31'b0, bif.issue_valid}, {31'b0, m_ivld});
    check("stall_count", {16'b0, bif.stall_count}, m_cnt);
    @(negedge clk);
  endtask

  // Mid-cycle asynchronous reset, then release on a falling edge.
  task automatic do_reset();
    bif.instr_valid = 0; bif.flush = 0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("rst_issue", bif.issue_instr, 32'h0);
    check("rst_ivld", {31'b0, bif.issue_valid}, 32'h0);
    check("rst_stall", {31'b0, bif.stall}, 32'h0);
    check("rst_ready", {31'b0, bif.instr_ready}, 32'h0);
    check("rst_cnt", {16'b0, bif.stall_count}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel_ready", {31'b0, bif.instr_ready}, 32'h1);
    check("rel_issue", bif.issue_instr, 32'h0);
  endtask

  initial begin
    logic [31:0] w;
    edge_no = 0;
    model_reset();
    bif.instr_valid = 0; bif.instr = '0; bif.flush = 0;
    @(negedge clk);
    do_reset();

    // Independent back-to-back stream
    step(1, 32'h00C0E004, 0);
    step(1, 32'h38C8E154, 0);
    check("indep_first", bif.issue_instr, 32'h00C0E004);
    step(0, 32'h0, 0);
    check("indep_second", bif.issue_instr, 32'h38C8E154);
    check("indep_cnt", {16'b0, bif.stall_count}, 32'd0);

    // RAW on rs1: exactly HAZ bubbles
    do_reset();
    step(1, 32'h00C0E004, 0);
    step(1, 32'h20460000, 0);
    for (int i = 0; i < HAZ; i++) begin
      step(0, 32'h0, 0);
      check("raw_bubble", bif.issue_instr, 32'h0);
    end
    step(0, 32'h0, 0);
    check("raw_issue", bif.issue_instr, 32'h20460000);
    check("raw_cnt", {16'b0, bif.stall_count}, HAZ);

    // I-form ignores rs2; r0 never hazards
    do_reset();
    step(1, 32'h00C0E004, 0);
    step(1, 32'h20403000, 0);
    step(1, 32'h00010800, 0);
    check("iform_issue", bif.issue_instr, 32'h20403000);
    step(1, 32'h00400000, 0);
    step(0, 32'h0, 0);
    check("r0_issue", bif.issue_instr, 32'h00400000);
    check("nohaz_cnt", {16'b0, bif.stall_count}, 32'd0);

    // Flush after first bubble of a RAW stall
    do_reset();
    step(1, 32'h00C0E004, 0);
    step(1, 32'h20460000, 0);
    step(0, 32'h0, 0);
    step(0, 32'h0, 1);
    check("flush_issue", bif.issue_instr, 32'h0);
    step(1, 32'h20460000, 0);
    check("flush_cnt", {16'b0, bif.stall_count}, 32'd1);
    step(0, 32'h0, 0);
    check("flush_reader", bif.issue_instr, 32'h20460000);

    // Reset mid-stall discards the pending word
    do_reset();
    step(1, 32'h00C0E004, 0);
    step(1, 32'h20460000, 0);
    step(0, 32'h0, 0);
    do_reset();
    step(0, 32'h0, 0);

    // Saturation from a preloaded count
    force dut.stall_cnt = 16'hFFFD;
    #1 release dut.stall_cnt;
    m_cnt = 16'hFFFD;
    for (int k = 0; k < 2; k++) begin
      step(1, 32'h00C0E004, 0);
      step(1, 32'h20460000, 0);
      for (int i = 0; i <= HAZ; i++) step(0, 32'h0, 0);
    end
    check("sat_cnt", {16'b0, bif.stall_count}, 32'h0000FFFF);

    // Randomized traffic over a small register set to provoke hazards
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      w = $urandom;
      w[25:21] = 5'($urandom_range(0, 3));
      w[20:16] = 5'($urandom_range(0, 3));
      w[15:11] = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) w = 32'h0;
      if ($urandom_range(0, 499) == 0) do_reset();
      step($urandom_range(0, 3) != 0, w, $urandom_range(0, 31) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/s1_issue_controller.md
# s1_issue_controller

Issue controller for the front of the pipeline, placed directly ahead of the S1 stage register. It accepts fetched instruction words over a valid/ready handshake and holds one pending word. It issues that word to the S1 register's `InstrIn` only when its source registers have no read-after-write (RAW) hazard against in-flight writes; otherwise it issues an all-zero NOP bubble. It also supports a pipeline flush and counts hazard stall cycles.

## Interface
- `HAZ_DEPTH`, default 3, range 1..4: number of cycles from issue until a write reaches the register file and is visible to a newly issued read.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `instr_valid`  in  1  a fetched word is present on `instr`.
- `instr`  in  32  fetched instruction word.
- `instr_ready`  out  1  combinational; `instr` is accepted on an edge where `instr_valid && instr_ready`.
- `flush`  in  1  synchronous; discard the pending word and all in-flight hazard state.
- `issue_instr`  out  32  registered; drives S1 `InstrIn`; `32'h0` means bubble.
- `issue_valid`  out  1  registered; high when `issue_instr` holds a real instruction.
- `stall`  out  1  combinational; high when the pending word is blocked by a hazard.
- `stall_count`  out  16  registered, saturating count of hazard bubbles.

## Operation
Instruction field decode, used by this block only:
- Destination `ws` = `[25:21]`; `rs1` = `[20:16]`; `rs2` = `[15:11]`.
- `imm_form` = `[29]`. When `imm_form` is 1, `rs2` is not a source.
- A word writes a register when it is nonzero and `ws != 0`.
- r0 never creates a hazard.

Pending register:
- Holds one word plus a `pend_valid` flag.
- Loaded on an accepted handshake.

Scoreboard:
- `HAZ_DEPTH` entries, each holding {`we`, `dest`}.
- Shifts every edge except flush: `sb[0]` takes the entry of the word issued on that edge (an empty entry on a bubble); `sb[i]` takes `sb[i-1]`.

Hazard condition:
- Asserted when `pend_valid` is high and some entry `sb[i]` has `we == 1` and `dest` equal to `rs1`, or equal to `rs2` when `imm_form == 0`.
- A word is never checked against its own destination.

Per-edge rules, in priority order:
1. `flush`:
   - `pend_valid` ← 0 and every scoreboard `we` ← 0.
   - `issue_instr` ← 0 and `issue_valid` ← 0.
   - `instr_ready` is 0 during flush, so no word is accepted.
   - `stall_count` holds its value.
2. `pend_valid` high and no hazard:
   - `issue_instr` ← pending word and `issue_valid` ← 1.
   - The issued word's entry goes into the scoreboard.
3. Otherwise:
   - `issue_instr` ← 0 and `issue_valid` ← 0.
   - If the bubble is due to a hazard, `stall_count` increments, saturating at 16'hFFFF.
   - A bubble caused by an empty pending register does not count.

Handshake:
- `instr_ready` = `rst` high && !`flush` && (!`pend_valid` || no hazard).
- When the pending word issues and a new word is accepted on the same edge, the new word replaces it. This gives full throughput of one word per cycle.
- `stall` = `pend_valid` && hazard.

## Timing
- Reset (`rst` low), taking effect asynchronously:
  - `issue_instr` = 0, `issue_valid` = 0, `stall_count` = 0.
  - `pend_valid` = 0 and the scoreboard is empty.
  - `stall` = 0 and `instr_ready` = 0 while reset is held.
- After reset is released, `instr_ready` = 1.
- Latency: a word accepted at edge E with no hazard appears on `issue_instr` after edge E+1.
- A dependent word that immediately follows its producer incurs exactly `HAZ_DEPTH` bubbles.
- An independent back-to-back stream incurs 0 bubbles.
- Reset asserted mid-stall discards the pending word at once. No partial issue may remain visible.

## Test plan
- Reset: assert `rst` low mid-cycle → all outputs 0 immediately. Release → `instr_ready` = 1 and `issue_instr` = 0.
- Independent stream: present `32'h00C0E004` then `32'h38C8E154` back-to-back → both issued on consecutive cycles, `stall` never high, `stall_count` = 0.
- RAW on `rs1`: present `32'h00C0E004` (writes r6) then `32'h20460000` (I-form, reads r6) → 3 cycles of `issue_instr` = 0 with `stall` = 1 and `instr_ready` = 0, then `32'h20460000` issues; `stall_count` = 3.
- I-form ignores `rs2`, and r0 does not hazard:
  - `32'h00C0E004` then `32'h20403000` (bits [15:11] = 6, `imm_form` = 1) → no bubble.
  - A word with `ws` = 0 followed by a reader of r0 → no bubble.
- Flush mid-stall: during the RAW scenario, assert `flush` for one cycle after the first bubble → next `issue_instr` = 0, `stall` = 0, `stall_count` holds 1. A following reader of r6 then issues with no bubble.
- Saturation: preload `stall_count` near its maximum by a long hazard sequence (or use a forced value) → the count holds at 16'hFFFF and does not wrap.
